turn_timer: RTL and testbench

TURN_TIMER -- requirements
Module: turn_timer

---
 rtl/turn_timer.sv | 103 ++++++++++
 tb/tb_turn_timer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/turn_timer.sv
// turn_timer: per-turn countdown with a one-second prescaler and BCD display digits.
// Latency: finished rises TURN_SECONDS*CLK_HZ edges after the reload edge; outputs other than finished are combinational.
// Backpressure: none; the block runs freely and any estado change restarts the budget.
//
// Ports:
//   clk          - single clock; all state updates on its rising edge
//   rst          - synchronous active-low reset
//   estado       - game state code; 0 = idle, any other value = a timed turn
//   finished     - registered one-cycle pulse when the turn budget expires
//   seconds_left - remaining seconds of the current turn
//   tens, units  - BCD digits of seconds_left
//   active       - high while the countdown is running
module turn_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] estado,
  output logic       finished,
  output logic [4:0] seconds_left,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       active
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [4:0]    TURN_SEC  = 5'(TURN_SECONDS);

  logic [3:0]    estado_q,       estado_d;
  logic [PW-1:0] prescaler_q,    prescaler_d;
  logic [4:0]    seconds_left_q, seconds_left_d;
  logic          finished_q,     finished_d;

  // Next-state logic. Priority: estado change (reload) > idle hold >
  // counting > hold at zero. finished_d defaults to 0 so the pulse can
  // only come from the 1 -> 0 step of the counting branch.
  always_comb begin
    estado_d       = estado_q;
    prescaler_d    = prescaler_q;
    seconds_left_d = seconds_left_q;
    finished_d     = 1'b0;

    if (estado != estado_q) begin
      // Any change, including non-zero to a different non-zero code,
      // starts a fresh turn. This also beats a coincident expiry.
      estado_d       = estado;
      prescaler_d    = '0;
      seconds_left_d = TURN_SEC;
    end else if (estado_q == 4'd0) begin
      prescaler_d    = '0;
      seconds_left_d = TURN_SEC;
    end else if (seconds_left_q != 5'd0) begin
      if (prescaler_q == PRESC_MAX) begin
        prescaler_d    = '0;
        seconds_left_d = seconds_left_q - 5'd1;
        finished_d     = (seconds_left_q == 5'd1);
      end else begin
        prescaler_d    = prescaler_q + PRESC_ONE;
      end
    end
    // seconds_left == 0 with a stable estado: everything holds.
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q       <= 4'd0;
      prescaler_q    <= '0;
      seconds_left_q <= TURN_SEC;
      finished_q     <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      prescaler_q    <= prescaler_d;
      seconds_left_q <= seconds_left_d;
      finished_q     <= finished_d;
    end
  end

  assign finished     = finished_q;
  assign seconds_left = seconds_left_q;
  assign active       = (estado_q != 4'd0) && (seconds_left_q != 5'd0) && (estado == estado_q);

  // BCD split of a 0..31 value. The units digit is always below 10, so it
  // can be computed in 4-bit arithmetic: subtracting the tens offset modulo
  // 16 (30 -> 14, 20 -> 4, 10 -> 10) gives the exact result.
  always_comb begin
    tens  = 4'd0;
    units = seconds_left_q[3:0];
    if (seconds_left_q >= 5'd30) begin
      tens  = 4'd3;
      units = seconds_left_q[3:0] - 4'd14;
    end else if (seconds_left_q >= 5'd20) begin
      tens  = 4'd2;
      units = seconds_left_q[3:0] - 4'd4;
    end else if (seconds_left_q >= 5'd10) begin
      tens  = 4'd1;
      units = seconds_left_q[3:0] - 4'd10;
    end
  end

endmodule

// File: tb/tb_turn_timer.sv
module tb_turn_timer;

  logic       clk;
  logic       rst;
  logic [3:0] estado;
  logic       finished;
  logic [4:0] seconds_left;
  logic [3:0] tens;
  logic [3:0] units;
  logic       active;

  logic [3:0] estado2;
  logic       finished2;
  logic [4:0] seconds_left2;
  logic [3:0] tens2;
  logic [3:0] units2;
  logic       active2;

  int checks = 0;
  int errors = 0;

  turn_timer #(.CLK_HZ(4), .TURN_SECONDS(3)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .estado       (estado),
    .finished     (finished),
    .seconds_left (seconds_left),
    .tens         (tens),
    .units        (units),
    .active       (active)
  );

  turn_timer #(.CLK_HZ(2), .TURN_SECONDS(15)) u_bcd (
    .clk          (clk),
    .rst          (rst),
    .estado       (estado2),
    .finished     (finished2),
    .seconds_left (seconds_left2),
    .tens         (tens2),
    .units        (units2),
    .active       (active2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge where checks happen
  // and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    estado  = 4'd0;
    estado2 = 4'd0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    chk("rst_sec", seconds_left, 3);
    chk("rst_fin", finished, 0);
    chk("rst_act", active, 0);
    chk("rst_tens", tens, 0);
    chk("rst_units", units, 3);
    chk("rst15_tens", tens2, 1);
    chk("rst15_units", units2, 5);
    chk("rst15_act", active2, 0);

    // Idle for 100 cycles
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("idle_sec", seconds_left, 3);
      chk("idle_fin", finished, 0);
    end

    // Basic expiry
    estado = 4'd1;
    tick();
    chk("exp_reload_sec", seconds_left, 3);
    chk("exp_reload_act", active, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("exp_sec", seconds_left, 3 - k / 4);
      chk("exp_fin", finished, (k == 12) ? 1 : 0);
      chk("exp_act", active, (k == 12) ? 0 : 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("exp_after_fin", finished, 0);
      chk("exp_after_sec", seconds_left, 0);
      chk("exp_after_act", active, 0);
    end

    // Turn change restart: turn starts, estado changes at edge +7
    estado = 4'd3;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rs_pre_sec", seconds_left, 3 - k / 4);
      chk("rs_pre_fin", finished, 0);
    end
    estado = 4'd4;
    tick();
    chk("rs_reload_sec", seconds_left, 3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("rs_sec", seconds_left, 3 - k / 4);
      chk("rs_fin", finished, (k == 12) ? 1 : 0);
    end

    // Collision: estado changes on the edge that would expire the count
    estado = 4'd6;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("col_pre_fin", finished, 0);
    end
    chk("col_pre_sec", seconds_left, 1);
    estado = 4'd7;
    tick();
    chk("col_fin", finished, 0);
    chk("col_sec", seconds_left, 3);
    chk("col_act", active, 1);
    tick();
    chk("col_after_fin", finished, 0);

    // Mid-operation reset at edge +5
    estado = 4'd1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    chk("mr_pre_sec", seconds_left, 2);
    rst = 1'b0;
    tick();
    chk("mr_sec", seconds_left, 3);
    chk("mr_fin", finished, 0);
    chk("mr_act", active, 0);
    rst = 1'b1;
    tick();
    chk("mr_reload_sec", seconds_left, 3);
    chk("mr_reload_act", active, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("mr_sec_cnt", seconds_left, 3 - k / 4);
      chk("mr_fin_cnt", finished, (k == 12) ? 1 : 0);
    end

    // BCD stepping with TURN_SECONDS=15, CLK_HZ=2
    estado2 = 4'd5;
    tick();
    chk("bcd_reload_tens", tens2, 1);
    chk("bcd_reload_units", units2, 5);
    for (int k = 1; k <= 30; k++) begin
      int s;
      tick();
      s = 15 - k / 2;
      chk("bcd_sec", seconds_left2, s);
      chk("bcd_tens", tens2, s / 10);
      chk("bcd_units", units2, s % 10);
      chk("bcd_fin", finished2, (k == 30) ? 1 : 0);
    end
    tick();
    chk("bcd_after_fin", finished2, 0);
    chk("bcd_after_act", active2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
